// File: rtl/fix2float_rr_arbiter.sv
// Purpose: round-robin share of one external fix64->float32 converter among NUM_REQ requesters.
// Latency: operand accepted in cycle N -> result valid in cycle N+2; one result per 2 cycles sustained.
// Backpressure: a held result (out_ready_i=0) stalls the unit and blocks all grants; retire and next grant share a cycle.
module fix2float_rr_arbiter #(
    // Stand-in for the CVA6 configuration object; carried for interface compatibility only.
    parameter int unsigned CVA6Cfg = 0,
    parameter int unsigned NUM_REQ = 4,
    // Width of the converter's float output bus (riscv::xlen_t); only [31:0] is meaningful.
    parameter int unsigned XLEN    = 64,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ-1:0][63:0] req_fix_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [63:0]              cvt_fix_o,
    input  logic [XLEN-1:0]          cvt_float_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_float_o,
    output logic [ID_W-1:0]          out_id_o,
    output logic                     busy_o
);

    localparam int unsigned cfg_unused = CVA6Cfg;

    typedef enum logic [1:0] {
        IDLE,
        CVT,
        OUT
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_q;
    logic [ID_W-1:0]   id_q;
    logic [63:0]       op_q;
    logic [31:0]       res_q;
    logic [ID_W-1:0]   win;
    logic              any_vld;
    logic              grant_en;
    logic              accept;
    int unsigned       idx;
    logic              unused_hi;

    // Upper converter bits carry nothing for single precision.
    assign unused_hi = ^cvt_float_i[XLEN-1:32];

    // Winner search: first valid requester starting at rr_q, wrapping past NUM_REQ-1.
    always_comb begin
        any_vld = 1'b0;
        win     = '0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_vld && req_valid_i[idx[ID_W-1:0]]) begin
                any_vld = 1'b1;
                win     = idx[ID_W-1:0];
            end
        end
    end

    // Grants are possible when empty, or when the held result retires this same cycle.
    assign grant_en    = (state_q == IDLE) || ((state_q == OUT) && out_ready_i);
    assign accept      = grant_en && any_vld;
    assign req_ready_o = accept ? (NUM_REQ'(1) << win) : '0;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CVT;
                end
            end
            CVT: begin
                state_d = OUT;
            end
            OUT: begin
                if (out_ready_i) begin
                    state_d = accept ? CVT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand/tag capture on accept, result capture at the end of the convert cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= req_fix_i[win];
                id_q <= win;
                rr_q <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
            end
            if (state_q == CVT) begin
                res_q <= cvt_float_i[31:0];
            end
        end
    end

    assign cvt_fix_o   = op_q;
    assign out_valid_o = (state_q == OUT);
    assign out_float_o = res_q;
    assign out_id_o    = id_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_fix2float_rr_arbiter.sv
// Purpose: self-checking bench for fix2float_rr_arbiter with a truncating fix64->float32 converter stub.
// Latency: directed scenarios check exact cycles; a random phase compares against a queue-based timeline model.
// Backpressure: out_ready is toggled both deliberately and randomly.
module tb_fix2float_rr_arbiter;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic [3:0]       req_valid;
    logic [3:0][63:0] req_fix;
    logic [3:0]       req_ready;
    logic [63:0]      cvt_fix;
    logic [63:0]      cvt_float;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_float;
    logic [1:0]       out_id;
    logic             busy;

    int checks = 0;
    int errors = 0;

    fix2float_rr_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_fix_i   (req_fix),
        .req_ready_o (req_ready),
        .cvt_fix_o   (cvt_fix),
        .cvt_float_i (cvt_float),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_float_o (out_float),
        .out_id_o    (out_id),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Q32.32 -> float32, magnitude truncated; stands in for the external converter.
    function automatic logic [31:0] conv(input logic [63:0] x);
        logic        s;
        logic [63:0] a;
        int          msb;
        logic [7:0]  e;
        logic [22:0] m;
        if (x == 64'd0) return 32'd0;
        s   = x[63];
        a   = s ? -x : x;
        msb = 0;
        for (int i = 0; i < 64; i++) if (a[i]) msb = i;
        e = 8'(msb - 32 + 127);
        if (msb >= 23) m = 23'(a >> (msb - 23));
        else           m = 23'(a << (23 - msb));
        return {s, e, m};
    endfunction

    // Upper half is junk so that any use of it by the DUT shows up.
    always_comb cvt_float = {32'hA5A5_5A5A, conv(cvt_fix)};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        req_valid = '0;
        req_fix   = '0;
        out_ready = 1'b1;
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni    = 1'b0;
        req_valid = '0;
        req_fix   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_float !== 32'd0) begin errors++; $display("FAIL reset_out_float got %h want 0", out_float); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id got %0d want 0", out_id); end
        checks++; if (cvt_fix !== 64'd0) begin errors++; $display("FAIL reset_cvt_fix got %h want 0", cvt_fix); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_ni = 1'b1;
    endtask

    task automatic test_single();
        logic [63:0] fx [2];
        logic [31:0] fl [2];
        fx[0] = 64'h0000_0001_0000_0000; fl[0] = 32'h3F80_0000;
        fx[1] = 64'hFFFF_FFFF_0000_0000; fl[1] = 32'hBF80_0000;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            req_fix[0] = fx[k];
            req_valid  = 4'b0001;
            #1;
            checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", req_ready); end
            tick();
            req_valid = '0;
            #1;
            checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_cvt valid=%b busy=%b want 0/1", out_valid, busy); end
            checks++; if (cvt_fix !== fx[k]) begin errors++; $display("FAIL single_cvt_fix got %h want %h", cvt_fix, fx[k]); end
            tick();
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b want 1", out_valid); end
            checks++; if (out_float !== fl[k]) begin errors++; $display("FAIL single_out_float got %h want %h", out_float, fl[k]); end
            checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL single_out_id got %0d want 0", out_id); end
            tick();
            #1;
            checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_idle busy=%b valid=%b want 0/0", busy, out_valid); end
        end
    endtask

    task automatic test_all4();
        logic [63:0] fx [4];
        logic [31:0] fl [4];
        logic [3:0]  oh;
        int          e;
        fx[0] = 64'h0000_0002_8000_0000; fl[0] = 32'h4020_0000;
        fx[1] = 64'h0000_0000_8000_0000; fl[1] = 32'h3F00_0000;
        fx[2] = 64'h0000_0000_0000_0000; fl[2] = 32'h0000_0000;
        fx[3] = 64'h0000_0001_0000_0000; fl[3] = 32'h3F80_0000;
        do_reset();
        for (int r = 0; r < 4; r++) req_fix[r] = fx[r];
        req_valid = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            e  = g % 4;
            oh = 4'b0001 << e;
            checks++; if (req_ready !== oh) begin errors++; $display("FAIL all4_grant%0d got %b want %b", g, req_ready, oh); end
            tick();
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL all4_cvt_ready%0d got %b want 0000", g, req_ready); end
            tick();
            if (g == 4) req_valid = '0;
            #1;
            checks++; if (out_valid !== 1'b1 || out_float !== fl[e] || out_id !== 2'(e))
                begin errors++; $display("FAIL all4_result%0d got v=%b %h id%0d want 1 %h id%0d", g, out_valid, out_float, out_id, fl[e], e); end
        end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready  = 1'b0;
        req_fix[0] = 64'h0000_0003_0000_0000;
        req_fix[1] = 64'hFFFF_FFFF_8000_0000;
        req_valid  = 4'b0011;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0 got %b want 0001", req_ready); end
        tick(); #1;
        tick(); #1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1 || out_float !== 32'h4040_0000 || out_id !== 2'd0 || req_ready !== 4'b0000)
                begin errors++; $display("FAIL bp_hold%0d got v=%b %h id%0d rdy=%b want 1 40400000 id0 0000", k, out_valid, out_float, out_id, req_ready); end
            tick(); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_grant got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        #1;
        tick(); #1;
        checks++; if (out_valid !== 1'b1 || out_float !== 32'hBF00_0000 || out_id !== 2'd1)
            begin errors++; $display("FAIL bp_second got v=%b %h id%0d want 1 bf000000 id1", out_valid, out_float, out_id); end
        tick();
    endtask

    task automatic test_fairness();
        int seq [3];
        seq[0] = 3; seq[1] = 1; seq[2] = 3;
        do_reset();
        req_fix[1] = 64'h0000_0000_4000_0000;
        req_fix[3] = 64'hFFFF_FFFE_0000_0000;
        req_valid  = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL fair_setup got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        #1;
        tick();
        req_valid = 4'b1010;
        #1;
        checks++; if (out_id !== 2'd1 || out_float !== 32'h3E80_0000) begin errors++; $display("FAIL fair_setup_out got id%0d %h want id1 3e800000", out_id, out_float); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (req_ready !== (4'b0001 << seq[k])) begin errors++; $display("FAIL fair_grant%0d got %b want req%0d", k, req_ready, seq[k]); end
            tick();
            if (k == 2) req_valid = '0;
            #1;
            tick(); #1;
            checks++; if (out_valid !== 1'b1 || out_id !== 2'(seq[k]) || out_float !== conv(req_fix[seq[k]]))
                begin errors++; $display("FAIL fair_result%0d got v=%b id%0d %h want id%0d", k, out_valid, out_id, out_float, seq[k]); end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_fix[2] = 64'h0000_0005_0000_0000;
        req_valid  = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rmid_grant got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        rst_ni    = 1'b0;
        #1;
        tick(); #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_after got v=%b busy=%b want 0/0", out_valid, busy); end
        rst_ni     = 1'b1;
        req_fix[0] = 64'h0000_0001_0000_0000;
        req_fix[3] = 64'h0000_0002_0000_0000;
        req_valid  = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_rr_cleared got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale_cvt got v=%b want 0", out_valid); end
        tick(); #1;
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_float !== 32'h3F80_0000)
            begin errors++; $display("FAIL rmid_result got v=%b id%0d %h want 1 id0 3f800000", out_valid, out_id, out_float); end
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_quiet%0d got v=%b want 0", k, out_valid); end
        end
    endtask

    task automatic test_drop_pulse();
        do_reset();
        req_fix[0] = 64'h0000_0001_0000_0000;
        req_valid  = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL drop_grant got %b want 0001", req_ready); end
        tick();
        req_fix[2] = 64'h0000_0007_0000_0000;
        req_valid  = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL drop_cvt_ready got %b want 0000", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd0 || req_ready !== 4'b0000)
            begin errors++; $display("FAIL drop_out got v=%b id%0d rdy=%b want 1 id0 0000", out_valid, out_id, req_ready); end
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || req_ready !== 4'b0000)
                begin errors++; $display("FAIL drop_idle%0d got busy=%b v=%b rdy=%b want 0 0 0000", k, busy, out_valid, req_ready); end
        end
    endtask

    typedef struct {
        int          id;
        logic [31:0] fl;
        int          t;
    } exp_t;

    task automatic test_random();
        exp_t       q [$];
        exp_t       it;
        int         m_rr;
        int         cyc;
        int         w;
        logic [3:0] g_prev;
        logic [3:0] exp_rdy;
        logic       exp_vld;
        logic       can_grant;
        do_reset();
        m_rr   = 0;
        cyc    = 0;
        g_prev = '0;
        for (int n = 0; n < 600; n++) begin
            tick();
            // Requesters hold their operand until served; occasionally drop valid unserved.
            for (int r = 0; r < 4; r++) begin
                if (req_valid[r] && !g_prev[r]) begin
                    if ($urandom_range(0, 9) == 0) req_valid[r] = 1'b0;
                end else begin
                    req_valid[r] = ($urandom_range(0, 2) != 0);
                    case ($urandom_range(0, 3))
                        0:       req_fix[r] = 64'd0;
                        1:       req_fix[r] = {32'(signed'($urandom_range(0, 20)) - 10), $urandom};
                        default: req_fix[r] = {$urandom, $urandom};
                    endcase
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_vld   = (q.size() != 0) && (q[0].t <= cyc);
            can_grant = (q.size() == 0) || (exp_vld && out_ready);
            w = -1;
            for (int k = 0; k < 4; k++) if (w < 0 && req_valid[(m_rr + k) % 4]) w = (m_rr + k) % 4;
            exp_rdy = (can_grant && w >= 0) ? (4'b0001 << w) : 4'b0000;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready cyc%0d got %b want %b", cyc, req_ready, exp_rdy); end
            checks++; if (out_valid !== exp_vld) begin errors++; $display("FAIL rand_valid cyc%0d got %b want %b", cyc, out_valid, exp_vld); end
            if (exp_vld) begin
                checks++; if (out_float !== q[0].fl || out_id !== 2'(q[0].id))
                    begin errors++; $display("FAIL rand_result cyc%0d got %h id%0d want %h id%0d", cyc, out_float, out_id, q[0].fl, q[0].id); end
                if (out_ready) void'(q.pop_front());
            end
            if (exp_rdy != 4'b0000) begin
                it.id = w;
                it.fl = conv(req_fix[w]);
                it.t  = cyc + 2;
                q.push_back(it);
                m_rr = (w + 1) % 4;
            end
            g_prev = exp_rdy;
            cyc++;
        end
        tick();
        req_valid = '0;
    endtask

    initial begin
        rst_ni    = 1'b0;
        req_valid = '0;
        req_fix   = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_all4();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_drop_pulse();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
